// File: rtl/control_unit.sv
// control_unit: multicycle controller for the 8-bit CPU datapath.
// Sequences fetch/decode, register ALU ops, LDM/STM through TR, and jumps.
`default_nettype none

module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] IrToCU,
    input  logic [4:0] DiToCU,
    input  logic [2:0] CznToCU,
    output logic       pcInc,
    output logic       pcLoadEn,
    output logic       diLoadEn,
    output logic       irWriteEn,
    output logic       trWriteEn,
    output logic       reg1Or2,
    output logic       PcOrTR,
    output logic       regOrMem,
    output logic       RegBOr0,
    output logic       RegAOr0,
    output logic       bRegWriteEn,
    output logic       aRegWriteEn,
    output logic       aluResWriteEn,
    output logic       ldCZN,
    output logic       accumulatorWriteEn,
    output logic       memoryReadEn,
    output logic       memoryWriteEn,
    output logic [1:0] aluOpControl,
    output logic [3:0] stateOut
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        RD_B    = 4'd2,
        RD_A    = 4'd3,
        EXEC    = 4'd4,
        WB      = 4'd5,
        LD_MEM  = 4'd6,
        LD_PASS = 4'd7,
        ST_B    = 4'd8,
        ST_PASS = 4'd9,
        ST_MEM  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    state_t state;
    state_t next_state;

    // The register fields in DI are consumed by the datapath, not by the controller.
    logic unused_di;
    assign unused_di = ^DiToCU;

    logic [2:0] opcode;
    assign opcode = IrToCU[3:1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    assign stateOut = state;

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:   next_state = DECODE;
            DECODE: begin
                case (opcode)
                    3'b000:  next_state = LD_MEM;
                    3'b001:  next_state = ST_B;
                    3'b010:  next_state = JUMP;
                    3'b011:  next_state = CznToCU[1] ? JUMP : FETCH;
                    3'b100:  next_state = CznToCU[0] ? JUMP : FETCH;
                    3'b101:  next_state = CznToCU[2] ? JUMP : FETCH;
                    default: next_state = RD_B;
                endcase
            end
            RD_B:    next_state = RD_A;
            RD_A:    next_state = EXEC;
            EXEC:    next_state = WB;
            WB:      next_state = FETCH;
            LD_MEM:  next_state = LD_PASS;
            LD_PASS: next_state = WB;
            ST_B:    next_state = ST_PASS;
            ST_PASS: next_state = ST_MEM;
            ST_MEM:  next_state = FETCH;
            JUMP:    next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    // Outputs are decoded from the current state and forced low while reset is held,
    // so an abandoned instruction cannot issue a write after the reset edge.
    always_comb begin
        pcInc              = 1'b0;
        pcLoadEn           = 1'b0;
        diLoadEn           = 1'b0;
        irWriteEn          = 1'b0;
        trWriteEn          = 1'b0;
        reg1Or2            = 1'b0;
        PcOrTR             = 1'b0;
        regOrMem           = 1'b0;
        RegBOr0            = 1'b0;
        RegAOr0            = 1'b0;
        bRegWriteEn        = 1'b0;
        aRegWriteEn        = 1'b0;
        aluResWriteEn      = 1'b0;
        ldCZN              = 1'b0;
        accumulatorWriteEn = 1'b0;
        memoryReadEn       = 1'b0;
        memoryWriteEn      = 1'b0;
        aluOpControl       = 2'b00;
        if (rst) begin
            case (state)
                FETCH: begin
                    PcOrTR       = 1'b1;
                    memoryReadEn = 1'b1;
                    irWriteEn    = 1'b1;
                    pcInc        = 1'b1;
                end
                DECODE: begin
                    if (IrToCU[3:2] == 2'b11) begin
                        diLoadEn = 1'b1;
                    end else begin
                        PcOrTR       = 1'b1;
                        memoryReadEn = 1'b1;
                        trWriteEn    = 1'b1;
                        pcInc        = 1'b1;
                    end
                end
                RD_B: begin
                    regOrMem    = 1'b1;
                    bRegWriteEn = 1'b1;
                end
                RD_A: begin
                    reg1Or2     = 1'b1;
                    aRegWriteEn = 1'b1;
                end
                EXEC: begin
                    aluOpControl  = IrToCU[1:0];
                    aluResWriteEn = 1'b1;
                    ldCZN         = 1'b1;
                end
                WB: begin
                    accumulatorWriteEn = 1'b1;
                end
                LD_MEM: begin
                    memoryReadEn = 1'b1;
                    bRegWriteEn  = 1'b1;
                end
                LD_PASS: begin
                    RegAOr0       = 1'b1;
                    aluResWriteEn = 1'b1;
                    ldCZN         = 1'b1;
                end
                ST_B: begin
                    regOrMem    = 1'b1;
                    bRegWriteEn = 1'b1;
                end
                ST_PASS: begin
                    RegAOr0       = 1'b1;
                    aluResWriteEn = 1'b1;
                end
                ST_MEM: begin
                    memoryWriteEn = 1'b1;
                end
                JUMP: begin
                    pcLoadEn = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// tb_control_unit: directed checks of control_unit state sequencing and output decode.
`default_nettype none

module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [3:0] IrToCU;
    logic [4:0] DiToCU;
    logic [2:0] CznToCU;
    logic       pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn;
    logic       reg1Or2, PcOrTR, regOrMem, RegBOr0, RegAOr0;
    logic       bRegWriteEn, aRegWriteEn, aluResWriteEn, ldCZN, accumulatorWriteEn;
    logic       memoryReadEn, memoryWriteEn;
    logic [1:0] aluOpControl;
    logic [3:0] stateOut;

    int n_checks = 0;
    int n_fail   = 0;

    control_unit dut (
        .clk               (clk),
        .rst               (rst),
        .IrToCU            (IrToCU),
        .DiToCU            (DiToCU),
        .CznToCU           (CznToCU),
        .pcInc             (pcInc),
        .pcLoadEn          (pcLoadEn),
        .diLoadEn          (diLoadEn),
        .irWriteEn         (irWriteEn),
        .trWriteEn         (trWriteEn),
        .reg1Or2           (reg1Or2),
        .PcOrTR            (PcOrTR),
        .regOrMem          (regOrMem),
        .RegBOr0           (RegBOr0),
        .RegAOr0           (RegAOr0),
        .bRegWriteEn       (bRegWriteEn),
        .aRegWriteEn       (aRegWriteEn),
        .aluResWriteEn     (aluResWriteEn),
        .ldCZN             (ldCZN),
        .accumulatorWriteEn(accumulatorWriteEn),
        .memoryReadEn      (memoryReadEn),
        .memoryWriteEn     (memoryWriteEn),
        .aluOpControl      (aluOpControl),
        .stateOut          (stateOut)
    );

    logic [18:0] outs;
    assign outs = {pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn, reg1Or2, PcOrTR,
                   regOrMem, RegBOr0, RegAOr0, bRegWriteEn, aRegWriteEn, aluResWriteEn,
                   ldCZN, accumulatorWriteEn, memoryReadEn, memoryWriteEn, aluOpControl};

    localparam logic [18:0] NONE    = 19'd0;
    localparam logic [18:0] OP_ADC  = 19'd1;
    localparam logic [18:0] OP_SUB  = 19'd2;
    localparam logic [18:0] OP_AND  = 19'd3;
    localparam logic [18:0] MWE     = 19'd1 << 2;
    localparam logic [18:0] MRD     = 19'd1 << 3;
    localparam logic [18:0] ACCWE   = 19'd1 << 4;
    localparam logic [18:0] LDCZN   = 19'd1 << 5;
    localparam logic [18:0] ALUWE   = 19'd1 << 6;
    localparam logic [18:0] AWE     = 19'd1 << 7;
    localparam logic [18:0] BWE     = 19'd1 << 8;
    localparam logic [18:0] RA0     = 19'd1 << 9;
    localparam logic [18:0] REGMEM  = 19'd1 << 11;
    localparam logic [18:0] PCTR    = 19'd1 << 12;
    localparam logic [18:0] R1OR2   = 19'd1 << 13;
    localparam logic [18:0] TRWE    = 19'd1 << 14;
    localparam logic [18:0] IRWE    = 19'd1 << 15;
    localparam logic [18:0] DILD    = 19'd1 << 16;
    localparam logic [18:0] PCLD    = 19'd1 << 17;
    localparam logic [18:0] PCINC   = 19'd1 << 18;

    localparam logic [18:0] O_FETCH  = PCTR | MRD | IRWE | PCINC;
    localparam logic [18:0] O_DECMEM = PCTR | MRD | TRWE | PCINC;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] exp_st, input logic [18:0] exp_o);
        n_checks++;
        assert (stateOut === exp_st) else begin
            n_fail++;
            $error("FAIL %s state: got %0d expected %0d", tag, stateOut, exp_st);
        end
        n_checks++;
        assert (outs === exp_o) else begin
            n_fail++;
            $error("FAIL %s outputs: got %b expected %b", tag, outs, exp_o);
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] exp_st, input logic [18:0] exp_o);
        @(negedge clk);
        chk(tag, exp_st, exp_o);
    endtask

    initial begin
        rst     = 1'b0;
        IrToCU  = 4'h0;
        DiToCU  = 5'b0;
        CznToCU = 3'b0;

        cyc("rst0", 4'd0, NONE);
        cyc("rst1", 4'd0, NONE);
        cyc("rst2", 4'd0, NONE);

        // Register op SUB, IR=E6
        rst = 1'b1;
        IrToCU = 4'hE; DiToCU = 5'b00110; CznToCU = 3'b000;
        #1 chk("fetch_after_rst", 4'd0, O_FETCH);
        cyc("sub_decode", 4'd1, DILD);
        cyc("sub_rd_b",   4'd2, REGMEM | BWE);
        cyc("sub_rd_a",   4'd3, R1OR2 | AWE);
        cyc("sub_exec",   4'd4, ALUWE | LDCZN | OP_SUB);
        cyc("sub_wb",     4'd5, ACCWE);
        cyc("ldm_fetch",  4'd0, O_FETCH);

        // LDM, IR=03
        IrToCU = 4'h0;
        cyc("ldm_decode",  4'd1, O_DECMEM);
        cyc("ldm_mem",     4'd6, MRD | BWE);
        cyc("ldm_pass",    4'd7, RA0 | ALUWE | LDCZN);
        cyc("ldm_wb",      4'd5, ACCWE);
        cyc("stm_fetch",   4'd0, O_FETCH);

        // STM, IR=20
        IrToCU = 4'h2;
        cyc("stm_decode",  4'd1, O_DECMEM);
        cyc("stm_b",       4'd8, REGMEM | BWE);
        cyc("stm_pass",    4'd9, RA0 | ALUWE);
        cyc("stm_mem",     4'd10, MWE);
        cyc("jz_t_fetch",  4'd0, O_FETCH);

        // JZ taken / not taken (C set alone must not take JZ)
        IrToCU = 4'h6; CznToCU = 3'b010;
        cyc("jz_t_decode", 4'd1, O_DECMEM);
        cyc("jz_t_jump",   4'd11, PCLD);
        cyc("jz_n_fetch",  4'd0, O_FETCH);
        CznToCU = 3'b001;
        cyc("jz_n_decode", 4'd1, O_DECMEM);
        cyc("jc_t_fetch",  4'd0, O_FETCH);

        // JC taken / not taken
        IrToCU = 4'h8; CznToCU = 3'b001;
        cyc("jc_t_decode", 4'd1, O_DECMEM);
        cyc("jc_t_jump",   4'd11, PCLD);
        cyc("jc_n_fetch",  4'd0, O_FETCH);
        CznToCU = 3'b110;
        cyc("jc_n_decode", 4'd1, O_DECMEM);
        cyc("jn_t_fetch",  4'd0, O_FETCH);

        // JN taken / not taken
        IrToCU = 4'hA; CznToCU = 3'b100;
        cyc("jn_t_decode", 4'd1, O_DECMEM);
        cyc("jn_t_jump",   4'd11, PCLD);
        cyc("jn_n_fetch",  4'd0, O_FETCH);
        CznToCU = 3'b011;
        cyc("jn_n_decode", 4'd1, O_DECMEM);
        cyc("jmp_fetch",   4'd0, O_FETCH);

        // Unconditional JMP with no flags
        IrToCU = 4'h4; CznToCU = 3'b000;
        cyc("jmp_decode",  4'd1, O_DECMEM);
        cyc("jmp_jump",    4'd11, PCLD);
        cyc("adc_fetch",   4'd0, O_FETCH);

        // Opcode 110 register op (ADC)
        IrToCU = 4'hD;
        cyc("adc_decode",  4'd1, DILD);
        cyc("adc_rd_b",    4'd2, REGMEM | BWE);
        cyc("adc_rd_a",    4'd3, R1OR2 | AWE);
        cyc("adc_exec",    4'd4, ALUWE | LDCZN | OP_ADC);
        cyc("adc_wb",      4'd5, ACCWE);
        cyc("and_fetch",   4'd0, O_FETCH);

        // AND, then reset asserted in EXEC
        IrToCU = 4'hF;
        cyc("and_decode",  4'd1, DILD);
        cyc("and_rd_b",    4'd2, REGMEM | BWE);
        cyc("and_rd_a",    4'd3, R1OR2 | AWE);
        cyc("and_exec",    4'd4, ALUWE | LDCZN | OP_AND);
        rst = 1'b0;
        #1 chk("midrst_now", 4'd0, NONE);
        cyc("midrst_hold", 4'd0, NONE);
        rst = 1'b1;
        #1 chk("midrst_fetch", 4'd0, O_FETCH);
        cyc("midrst_decode", 4'd1, DILD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multicycle controller that sits beside the CPU datapath.
- Consumes the instruction-register opcode nibble, the DI register-field bits and the CZN flags.
- Drives every datapath load/select/enable and the ALU op code through one Moore/Mealy FSM.
- Sequences fetch, decode, register-register ALU ops, load/store to the 13-bit address space, and jumps.

Parameters:
none (state encoding fixed, 4-bit binary).

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset
IrToCU  in  4  IR[7:4]
DiToCU  in  5  DI[4:0]; [3:2]=Rs, [1:0]=Rd, [4] reserved
CznToCU  in  3  flags {N,Z,C} = [2],[1],[0]
pcInc, pcLoadEn  out  1 each  PC increment / load from TR
diLoadEn, irWriteEn, trWriteEn  out  1 each  register loads
reg1Or2  out  1  0: accumulator addr=DI[1:0] (Rd), 1: DI[3:2] (Rs)
PcOrTR  out  1  memory address source; 0: TR, 1: PC
regOrMem  out  1  B-reg input; 0: memory data, 1: accumulator
RegBOr0, RegAOr0  out  1 each  1 forces the ALU operand to zero
bRegWriteEn, aRegWriteEn, aluResWriteEn, ldCZN, accumulatorWriteEn  out  1 each
memoryReadEn, memoryWriteEn  out  1 each
aluOpControl  out  2  00 ADD, 01 ADC, 10 SUB, 11 AND
stateOut  out  4  current state code (debug/verification)

Behaviour:
- Memory read data is valid in the same cycle memoryReadEn is high; the capturing register latches it at the next rising edge.
- ISA, opcode IR[7:5]:
  - 000 LDM: Rd <- M[a]
  - 001 STM: M[a] <- Rd
  - 010 JMP
  - 011 JZ
  - 100 JC
  - 101 JN
  - 11x register op: Rd <- Rd op Rs, op = IR[5:4]
- Memory-ref instructions are two bytes; a = {IR[4:0], byte2}.
- LDM/STM use the Rd held in DI from the most recent register op (DI is not reloaded by memory-ref instructions).
- Every output not listed for a state is 0. Defaults are reg1Or2=0, PcOrTR=0, regOrMem=0, RegBOr0=0, RegAOr0=0, aluOpControl=00.
- States and codes:
  - FETCH(0): PcOrTR=1, memoryReadEn, irWriteEn, pcInc -> DECODE.
  - DECODE(1): reads IrToCU directly (Mealy).
    - IR[7:6]=11: diLoadEn -> RD_B.
    - Otherwise: PcOrTR=1, memoryReadEn, trWriteEn, pcInc. Next state: 000 -> LD_MEM, 001 -> ST_B, 010 -> JUMP, 011/100/101 -> JUMP if Z/C/N=1 else FETCH.
    - IR[7:5]=110/111 are both register ops.
  - RD_B(2): reg1Or2=0, regOrMem=1, bRegWriteEn -> RD_A.
  - RD_A(3): reg1Or2=1, aRegWriteEn -> EXEC.
  - EXEC(4): aluOpControl=IrToCU[1:0], aluResWriteEn, ldCZN -> WB.
  - WB(5): reg1Or2=0, accumulatorWriteEn -> FETCH.
  - LD_MEM(6): PcOrTR=0, memoryReadEn, regOrMem=0, bRegWriteEn -> LD_PASS.
  - LD_PASS(7): RegAOr0=1, aluOp=00, aluResWriteEn, ldCZN -> WB.
  - ST_B(8): reg1Or2=0, regOrMem=1, bRegWriteEn -> ST_PASS.
  - ST_PASS(9): RegAOr0=1, aluOp=00, aluResWriteEn (no ldCZN) -> ST_MEM.
  - ST_MEM(10): PcOrTR=0, memoryWriteEn -> FETCH.
  - JUMP(11): pcLoadEn -> FETCH.
- Cycle counts:
  - register op: 6 (FETCH, DECODE, RD_B, RD_A, EXEC, WB)
  - LDM: 5
  - STM: 5
  - JMP / taken branch: 3
  - not-taken branch: 2
- Branch condition is sampled from CznToCU in DECODE only.
- Flag updates during STM/branches cannot occur (ldCZN low).
- Reset:
  - rst low forces state=FETCH immediately; stateOut=0.
  - All outputs are 0 while rst is low, including the FETCH enables (gated by rst).
  - The first rising edge after release executes FETCH.
  - Reset mid-instruction abandons it; no partial write is issued after the rst fall.
- Illegal state codes 12-15 -> FETCH next edge, all outputs 0.
- pcInc and pcLoadEn are never high together; memoryReadEn and memoryWriteEn are never high together.

Test Plan:
- Reset/fetch: rst=0 for 3 cycles, then release. stateOut=0 and all outputs 0 during reset. First cycle after release: PcOrTR=1, memoryReadEn=1, irWriteEn=1, pcInc=1.
- Register op: IR=8'hE6 (SUB), DI=5'b00110. States 0,1,2,3,4,5,0. DECODE diLoadEn=1. RD_A reg1Or2=1. EXEC aluOpControl=10 with ldCZN=1. WB accumulatorWriteEn=1, reg1Or2=0.
- LDM: IR=8'h03. DECODE trWriteEn=1, pcInc=1. LD_MEM PcOrTR=0, bRegWriteEn=1, regOrMem=0. LD_PASS RegAOr0=1, aluOp=00, ldCZN=1. WB writes. Total 5 cycles.
- STM: IR=8'h20. States 0,1,8,9,10. ST_PASS ldCZN=0. ST_MEM memoryWriteEn=1, PcOrTR=0, memoryReadEn=0.
- Branches: JZ (IR=8'h60) with CznToCU=3'b010 -> JUMP, pcLoadEn=1 (3 cycles). With CznToCU=3'b000 -> FETCH after DECODE (2 cycles). Repeat for JC (3'b001) and JN (3'b100).
- Mid-op reset: assert rst in EXEC. aluResWriteEn and ldCZN drop immediately, no WB occurs, and the restart is at FETCH.
